// File: rtl/hazard_pkg.sv
// Shared constants and state encoding for the ID-stage hazard/stall unit.
package hazard_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational source/destination register comparator; register 0 never matches.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_rs,
    input  logic              i_use_rs,
    input  logic [ADDR_W-1:0] i_rt,
    input  logic              i_use_rt,
    input  logic [ADDR_W-1:0] i_write_reg,
    input  logic              i_reg_write,
    output logic              o_match
);

    logic w_dest_valid;
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_dest_valid = i_reg_write && (i_write_reg != ADDR_W'(REG_ZERO));
    assign w_rs_hit     = i_use_rs && (i_rs == i_write_reg);
    assign w_rt_hit     = i_use_rt && (i_rt == i_write_reg);
    assign o_match      = w_dest_valid && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection: bubble select, PC/IF-ID write enables and IF/ID flush.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_stall_unit #(
    parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W,
    parameter int LU_BR_STALL = 2,
    parameter int CNT_W       = 2,
    parameter int PERF_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UseRs,
    input  logic                  ID_UseRt,
    input  logic                  ID_Branch,
    input  logic                  ID_JR,
    input  logic                  ID_Taken,
    input  logic [REG_ADDR_W-1:0] EX_WriteReg,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] MEM_WriteReg,
    input  logic                  MEM_RegWrite,
    input  logic                  MEM_MemRead,
    output logic                  Hazard,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic [PERF_W-1:0]     StallCycles,
    output logic [PERF_W-1:0]     FlushCount
);
    import hazard_pkg::*;

    localparam logic [CNT_W:0] N_ONE = (CNT_W+1)'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_m_ex;
    logic             w_m_mem;
    logic             w_br;
    logic [CNT_W:0]   w_n;
    logic             w_stall;

    hazard_match #(.ADDR_W(REG_ADDR_W)) u_match_ex (
        .i_rs        (ID_Rs),
        .i_use_rs    (ID_UseRs),
        .i_rt        (ID_Rt),
        .i_use_rt    (ID_UseRt),
        .i_write_reg (EX_WriteReg),
        .i_reg_write (EX_RegWrite),
        .o_match     (w_m_ex)
    );

    hazard_match #(.ADDR_W(REG_ADDR_W)) u_match_mem (
        .i_rs        (ID_Rs),
        .i_use_rs    (ID_UseRs),
        .i_rt        (ID_Rt),
        .i_use_rt    (ID_UseRt),
        .i_write_reg (MEM_WriteReg),
        .i_reg_write (MEM_RegWrite),
        .o_match     (w_m_mem)
    );

    assign w_br = ID_Branch || ID_JR;

    // Stall length is decided only in IDLE; STALL ignores detection inputs.
    always_comb begin
        w_n = '0;
        if (r_state == ST_IDLE) begin
            if (EX_MemRead && w_m_ex) begin
                w_n = w_br ? (CNT_W+1)'(LU_BR_STALL) : N_ONE;
            end else if (w_br && w_m_ex) begin
                w_n = N_ONE;
            end else if (w_br && w_m_mem && MEM_MemRead) begin
                w_n = N_ONE;
            end
        end
    end

    assign w_stall   = !Rst && ((r_state == ST_STALL) || (w_n != '0));
    assign Hazard    = w_stall;
    assign PCWrite   = !w_stall;
    assign IFIDWrite = !w_stall;
    assign IFIDFlush = !Rst && ID_Taken && !w_stall;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_n > N_ONE) begin
                r_state <= ST_STALL;
                r_cnt   <= CNT_W'(w_n - N_ONE);
            end
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) begin
                r_state <= ST_IDLE;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_count;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (Hazard) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
            if (IFIDFlush) begin
                r_flush_count <= r_flush_count + PERF_W'(1);
            end
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench with an abstract remaining-stall-cycles model checked every cycle.
module tb_hazard_stall_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_branch;
    logic        id_jr;
    logic        id_taken;
    logic [4:0]  ex_wr;
    logic        ex_rw;
    logic        ex_mr;
    logic [4:0]  mem_wr;
    logic        mem_rw;
    logic        mem_mr;
    logic        hazard;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int n_pass  = 0;
    int n_total = 0;

    hazard_stall_unit #(
        .REG_ADDR_W  (5),
        .LU_BR_STALL (2),
        .CNT_W       (2),
        .PERF_W      (32)
    ) dut (
        .Clk          (clk),
        .Rst          (rst),
        .ID_Rs        (id_rs),
        .ID_Rt        (id_rt),
        .ID_UseRs     (id_use_rs),
        .ID_UseRt     (id_use_rt),
        .ID_Branch    (id_branch),
        .ID_JR        (id_jr),
        .ID_Taken     (id_taken),
        .EX_WriteReg  (ex_wr),
        .EX_RegWrite  (ex_rw),
        .EX_MemRead   (ex_mr),
        .MEM_WriteReg (mem_wr),
        .MEM_RegWrite (mem_rw),
        .MEM_MemRead  (mem_mr),
        .Hazard       (hazard),
        .PCWrite      (pc_write),
        .IFIDWrite    (ifid_write),
        .IFIDFlush    (ifid_flush),
        .StallCycles  (stall_cycles),
        .FlushCount   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- abstract model ----------------
    int          m_rem;
    int          m_rem_next;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;
    logic [31:0] m_stalls_next;
    logic [31:0] m_flushes_next;
    bit          m_valid = 1'b0;

    function automatic bit depends(input logic [4:0] wr, input logic rw);
        if (!rw || wr == 5'd0) return 1'b0;
        return (id_use_rs && id_rs == wr) || (id_use_rt && id_rt == wr);
    endfunction

    function automatic int needed_stalls();
        bit is_br;
        is_br = id_branch || id_jr;
        if (ex_mr && depends(ex_wr, ex_rw)) return is_br ? 2 : 1;
        if (is_br && depends(ex_wr, ex_rw)) return 1;
        if (is_br && mem_mr && depends(mem_wr, mem_rw)) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        int  n;
        bit  e_stall;
        bit  e_flush;
        n       = (m_rem > 0) ? 0 : needed_stalls();
        e_stall = !rst && (m_rem > 0 || n > 0);
        e_flush = !rst && id_taken && !e_stall;
        if (m_valid) begin
            check("m_hazard",    32'(hazard),     32'(e_stall));
            check("m_pcwrite",   32'(pc_write),   32'(!e_stall));
            check("m_ifidwrite", 32'(ifid_write), 32'(!e_stall));
            check("m_ifidflush", 32'(ifid_flush), 32'(e_flush));
`ifdef HAZARD_PERF_EN
            check("m_stallcyc",  stall_cycles, m_stalls);
            check("m_flushcnt",  flush_count,  m_flushes);
`else
            check("m_stallcyc",  stall_cycles, 32'd0);
            check("m_flushcnt",  flush_count,  32'd0);
`endif
        end
        if (rst) begin
            m_rem_next     = 0;
            m_stalls_next  = 32'd0;
            m_flushes_next = 32'd0;
        end else begin
            m_rem_next     = (m_rem > 0) ? m_rem - 1 : ((n > 0) ? n - 1 : 0);
            m_stalls_next  = m_stalls  + 32'(e_stall);
            m_flushes_next = m_flushes + 32'(e_flush);
        end
    end

    always @(posedge clk) begin
        m_rem     <= m_rem_next;
        m_stalls  <= m_stalls_next;
        m_flushes <= m_flushes_next;
        if (rst) m_valid <= 1'b1;
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(
        input logic r,
        input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
        input logic br, input logic jr, input logic tk,
        input logic [4:0] ew, input logic erw, input logic emr,
        input logic [4:0] mw, input logic mrw, input logic mmr
    );
        rst = r; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_branch = br; id_jr = jr; id_taken = tk;
        ex_wr = ew; ex_rw = erw; ex_mr = emr;
        mem_wr = mw; mem_rw = mrw; mem_mr = mmr;
    endtask

    // Literal expectations for the current vector, sampled mid-cycle.
    task automatic expect_lit(input string name, input logic h, input logic f);
        #6;
        check({name, "_hazard"},  32'(hazard),     32'(h));
        check({name, "_pcwrite"}, 32'(pc_write),   32'(!h));
        check({name, "_ifidwr"},  32'(ifid_write), 32'(!h));
        check({name, "_flush"},   32'(ifid_flush), 32'(f));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] perf_exp;

    initial begin
        m_rem = 0; m_rem_next = 0;
        m_stalls = 0; m_flushes = 0; m_stalls_next = 0; m_flushes_next = 0;
        drive(1, 8,1, 0,0, 1,0, 1, 8,1,1, 0,0,0);
        @(posedge clk); #1;

        // Reset with a hazard and a redirect present: outputs forced idle
        drive(1, 8,1, 0,0, 1,0, 1, 8,1,1, 0,0,0); expect_lit("rst_forced", 0, 0); next_cycle();
        drive(0, 0,0, 0,0, 0,0, 0, 0,0,0, 0,0,0); expect_lit("idle", 0, 0);
`ifdef HAZARD_PERF_EN
        perf_exp = 32'd0;
`else
        perf_exp = 32'd0;
`endif
        check("perf_after_rst", stall_cycles, perf_exp);
        next_cycle();

        // Load-use: one bubble, then clear once EX holds the bubble
        drive(0, 8,1, 3,1, 0,0, 0, 8,1,1, 0,0,0); expect_lit("lu_c1", 1, 0); next_cycle();
        drive(0, 8,1, 3,1, 0,0, 0, 0,0,0, 8,1,1); expect_lit("lu_c2", 0, 0); next_cycle();

        // Load then branch: two bubbles, second held with EX cleared
        drive(0, 8,1, 0,0, 1,0, 0, 8,1,1, 0,0,0); expect_lit("lbr_c1", 1, 0); next_cycle();
        drive(0, 8,1, 0,0, 1,0, 0, 0,0,0, 0,0,0); expect_lit("lbr_c2", 1, 0); next_cycle();
        drive(0, 8,1, 0,0, 1,0, 0, 0,0,0, 0,0,0); expect_lit("lbr_c3", 0, 0); next_cycle();

        // ALU then branch on rt
        drive(0, 2,1, 9,1, 1,0, 0, 9,1,0, 0,0,0); expect_lit("alubr_c1", 1, 0);
`ifdef HAZARD_PERF_EN
        perf_exp = 32'd3;
`else
        perf_exp = 32'd0;
`endif
        check("perf_three_stalls", stall_cycles, perf_exp);
        next_cycle();
        drive(0, 2,1, 9,1, 1,0, 0, 0,0,0, 9,1,0); expect_lit("alubr_c2", 0, 0); next_cycle();
        drive(0, 2,1, 9,1, 0,0, 0, 9,1,0, 0,0,0); expect_lit("alu_nobr", 0, 0); next_cycle();

        // Register zero never matches
        drive(0, 0,1, 0,1, 1,0, 0, 0,1,1, 0,1,1); expect_lit("zero_reg", 0, 0); next_cycle();

        // Load in MEM feeding a jr
        drive(0, 5,1, 0,0, 0,1, 0, 0,0,0, 5,1,1); expect_lit("memld_jr", 1, 0); next_cycle();
        drive(0, 5,1, 0,0, 0,1, 0, 0,0,0, 0,0,0); expect_lit("memld_jr2", 0, 0); next_cycle();
        drive(0, 5,1, 0,0, 0,0, 0, 0,0,0, 5,1,1); expect_lit("memld_nobr", 0, 0); next_cycle();

        // Flush with no hazard, then redirect ignored during a stall
        drive(0, 1,1, 2,1, 1,0, 1, 0,0,0, 0,0,0); expect_lit("flush", 0, 1); next_cycle();
        drive(0, 8,1, 0,0, 1,0, 0, 8,1,1, 0,0,0); expect_lit("fp_c1", 1, 0); next_cycle();
        drive(0, 8,1, 0,0, 1,0, 1, 0,0,0, 8,1,1); expect_lit("fp_c2", 1, 0); next_cycle();
        drive(0, 8,1, 0,0, 1,0, 1, 0,0,0, 0,0,0); expect_lit("fp_after", 0, 1); next_cycle();
        drive(0, 4,1, 0,0, 0,0, 1, 4,1,1, 0,0,0); expect_lit("lu_taken", 1, 0); next_cycle();
        drive(0, 4,1, 0,0, 0,0, 0, 0,0,0, 0,0,0); expect_lit("lu_taken2", 0, 0); next_cycle();

        // Reset during the second stall cycle, then during detection
        drive(0, 8,1, 0,0, 1,0, 0, 8,1,1, 0,0,0); expect_lit("rs_c1", 1, 0); next_cycle();
        drive(1, 8,1, 0,0, 1,0, 1, 0,0,0, 0,0,0); expect_lit("rs_c2", 0, 0); next_cycle();
        drive(0, 8,1, 0,0, 1,0, 0, 0,0,0, 0,0,0); expect_lit("rs_c3", 0, 0); next_cycle();
        drive(1, 8,1, 0,0, 1,0, 0, 8,1,1, 0,0,0); expect_lit("rd_c1", 0, 0); next_cycle();
        drive(0, 8,1, 0,0, 1,0, 0, 0,0,0, 0,0,0); expect_lit("rd_c2", 0, 0);
`ifdef HAZARD_PERF_EN
        perf_exp = 32'd0;
`else
        perf_exp = 32'd0;
`endif
        check("perf_cleared", stall_cycles, perf_exp);
        next_cycle();

        // Back-to-back stalls: load-branch then load-use
        drive(0, 6,1, 0,0, 1,0, 0, 6,1,1, 0,0,0); expect_lit("bb_c1", 1, 0); next_cycle();
        drive(0, 6,1, 0,0, 1,0, 0, 7,1,1, 0,0,0); expect_lit("bb_c2", 1, 0); next_cycle();
        drive(0, 7,1, 0,0, 0,0, 0, 7,1,1, 0,0,0); expect_lit("bb_c3", 1, 0); next_cycle();
        drive(0, 0,0, 0,0, 0,0, 0, 0,0,0, 0,0,0); expect_lit("bb_c4", 0, 0); next_cycle();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
